// File: rtl/error_inject_stream.sv
// Registered error injector for Hamming-code lab datapaths.
// Flips 0, 1 or 2 bits of each accepted codeword on a valid/ready stream.
// It emits the applied mask with the word.
// It keeps a saturating count of corrupted words.
module error_inject_stream #(
  parameter int          W         = 7,
  parameter int          POSW      = 3,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      mode,
  input  logic [POSW-1:0] pos_a,
  input  logic [POSW-1:0] pos_b,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_data,
  output logic [W-1:0]    out_mask,
  output logic [15:0]     inj_count
);

  typedef enum logic [1:0] {
    MODE_PASS   = 2'b00,
    MODE_SINGLE = 2'b01,
    MODE_DOUBLE = 2'b10,
    MODE_RANDOM = 2'b11
  } mode_e;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  logic [15:0]     lfsr;
  logic [W-1:0]    mask;
  logic [POSW-1:0] rand_pos;
  logic [POSW:0]   rand_ext;
  logic            accept;

  // A position at or beyond the word width flips nothing.
  function automatic logic [W-1:0] one_hot(input logic [POSW-1:0] pos);
    logic [W-1:0] v;
    v = '0;
    if (32'(pos) < W) v = {{(W-1){1'b0}}, 1'b1} << pos;
    return v;
  endfunction

  // The register is free when it is empty or it is draining this cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Fold the LFSR low bits into 0..W-1. One subtraction is enough because 2^POSW < 2W.
  always_comb begin
    rand_ext = {1'b0, lfsr[POSW-1:0]};
    if (rand_ext >= (POSW+1)'(W)) rand_ext = rand_ext - (POSW+1)'(W);
    rand_pos = rand_ext[POSW-1:0];
  end

  // Build the error mask for the current mode from the pre-advance LFSR value.
  // NOTE: every variable gets a default first so that no path leaves it unassigned.
  // An unassigned path would infer a latch.
  always_comb begin
    mask = '0;
    unique case (mode_e'(mode))
      MODE_PASS:   mask = '0;
      MODE_SINGLE: mask = one_hot(pos_a);
      MODE_DOUBLE: mask = one_hot(pos_a) | one_hot(pos_b);
      MODE_RANDOM: mask = one_hot(rand_pos);
      default:     mask = '0;
    endcase
  end

  // Output register: load on accept, empty on drain, otherwise hold the stalled word.
  // NOTE: sequential state uses non-blocking assignments. Every register here is reset.
  // These registers are flops, not memory, so the reset is cheap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mask  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= in_data ^ mask;
      out_mask  <= mask;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Galois LFSR (right shift). It advances only when a random-mode word is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else if (accept && (mode_e'(mode) == MODE_RANDOM)) begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  // Count accepted words that carried at least one flip, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inj_count <= '0;
    end else if (accept && (|mask) && (inj_count != 16'hFFFF)) begin
      inj_count <= inj_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_error_inject_stream.sv
// Self-checking bench for error_inject_stream.
// It compares the design against a transaction-level model of the output register.
// The model also tracks the random-position generator and the injection counter.
module tb_error_inject_stream;

  localparam int W = 7;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   mode = '0;
  logic [2:0]   pos_a = '0;
  logic [2:0]   pos_b = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic [W-1:0] out_mask;
  logic [15:0]  inj_count;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state.
  bit           m_valid;
  logic [W-1:0] m_data;
  logic [W-1:0] m_mask;
  int           m_count;
  logic [15:0]  m_lfsr;

  error_inject_stream #(.W(W), .POSW(3), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .pos_a(pos_a), .pos_b(pos_b),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_mask(out_mask), .inj_count(inj_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] bit_at(input int p);
    logic [W-1:0] v;
    v = '0;
    if (p < W) v[p] = 1'b1;
    return v;
  endfunction

  function automatic logic [W-1:0] ref_mask(input logic [1:0] md, input int pa, input int pb,
                                            input logic [15:0] lf);
    int r;
    case (md)
      2'd1:    return bit_at(pa);
      2'd2:    return bit_at(pa) | bit_at(pb);
      2'd3: begin
        r = int'(lf) % 8;
        if (r >= W) r -= W;
        return bit_at(r);
      end
      default: return '0;
    endcase
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] lf);
    return (lf >> 1) ^ (lf[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic model_reset();
    m_valid = 0; m_data = '0; m_mask = '0; m_count = 0; m_lfsr = 16'hACE1;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_valid"}, 64'(out_valid), 64'(m_valid));
    check({tag, "_data"},  64'(out_data),  64'(m_data));
    check({tag, "_mask"},  64'(out_mask),  64'(m_mask));
    check({tag, "_count"}, 64'(inj_count), 64'(m_count));
    check({tag, "_lfsr"},  64'(dut.lfsr),  64'(m_lfsr));
  endtask

  // Runs one clock. It is entered right after a negedge and leaves right after the next negedge.
  task automatic cycle(input string tag, input logic iv, input logic [1:0] md,
                       input logic [2:0] pa, input logic [2:0] pb,
                       input logic [W-1:0] d, input logic ordy, input bit chk);
    bit           acc;
    logic [W-1:0] m;
    in_valid = iv; mode = md; pos_a = pa; pos_b = pb; in_data = d; out_ready = ordy;
    #1;
    if (chk) check({tag, "_ready"}, 64'(in_ready), 64'(!m_valid || ordy));
    acc = iv && (!m_valid || ordy);
    m   = ref_mask(md, int'(pa), int'(pb), m_lfsr);
    @(posedge clk);
    if (acc) begin
      m_valid = 1; m_data = d ^ m; m_mask = m;
      if (m != '0 && m_count < 65535) m_count++;
      if (md == 2'd3) m_lfsr = lfsr_next(m_lfsr);
    end else if (ordy) begin
      m_valid = 0;
    end
    #1;
    if (chk) check_outputs(tag);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("reset");
    check("reset_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] held_lfsr;
    model_reset();
    @(negedge clk);
    do_reset();

    // Pass-through mode.
    cycle("t1", 1, 2'd0, 0, 0, 7'b1010101, 1, 1);
    check("t1_data_const", 64'(out_data), 64'h55);

    // Single flip, then an out-of-range position.
    cycle("t2a", 1, 2'd1, 6, 0, 7'h00, 1, 1);
    check("t2a_data_const", 64'(out_data), 64'h40);
    check("t2a_count_const", 64'(inj_count), 64'd1);
    cycle("t2b", 1, 2'd1, 7, 0, 7'h00, 1, 1);
    check("t2b_mask_const", 64'(out_mask), 64'h0);

    // Double flip, then identical positions.
    cycle("t3a", 1, 2'd2, 0, 3, 7'h7F, 1, 1);
    check("t3a_data_const", 64'(out_data), 64'h76);
    cycle("t3b", 1, 2'd2, 2, 2, 7'h00, 1, 1);
    check("t3b_mask_const", 64'(out_mask), 64'h04);

    // Random positions from the seed.
    do_reset();
    cycle("t4a", 1, 2'd3, 0, 0, 7'h00, 1, 1);
    check("t4a_mask_const", 64'(out_mask), 64'h02);
    check("t4a_lfsr_const", 64'(dut.lfsr), 64'hE270);
    cycle("t4b", 1, 2'd3, 0, 0, 7'h00, 1, 1);
    check("t4b_mask_const", 64'(out_mask), 64'h01);

    // Backpressure: hold a word for 5 cycles, then drain and accept in the same cycle.
    cycle("t5_drain", 0, 2'd0, 0, 0, 7'h00, 1, 1);
    cycle("t5_load", 1, 2'd1, 1, 0, 7'h33, 0, 1);
    held_lfsr = m_lfsr;
    for (int i = 0; i < 5; i++) begin
      cycle("t5_stall", 1, 2'd3, 4, 5, 7'h0F, 0, 1);
      check("t5_lfsr_frozen", 64'(dut.lfsr), 64'(held_lfsr));
    end
    cycle("t5_release", 1, 2'd3, 4, 5, 7'h0F, 1, 1);

    // Random traffic with random backpressure.
    for (int i = 0; i < 2000; i++) begin
      cycle("rand", 1'($urandom_range(0, 3) != 0), 2'($urandom), 3'($urandom), 3'($urandom),
            7'($urandom), 1'($urandom_range(0, 3) != 0), 1);
    end

    // Saturation of the injection counter.
    while (m_count < 65534) cycle("fill", 1, 2'd1, 0, 0, 7'h00, 1, 0);
    cycle("sat_a", 1, 2'd1, 0, 0, 7'h00, 1, 1);
    check("sat_a_const", 64'(inj_count), 64'hFFFF);
    cycle("sat_b", 1, 2'd2, 1, 5, 7'h00, 1, 1);
    check("sat_b_const", 64'(inj_count), 64'hFFFF);

    // Reset in the middle of a transfer drops the held word.
    cycle("pre_rst", 1, 2'd1, 3, 0, 7'h11, 0, 1);
    do_reset();
    check("mid_rst_valid", 64'(out_valid), 64'(0));
    check("mid_rst_count", 64'(inj_count), 64'(0));
    cycle("post_rst", 1, 2'd3, 0, 0, 7'h00, 1, 1);
    check("post_rst_seed_mask", 64'(out_mask), 64'h02);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
